// File: rtl/model_bus_pkg.sv
// Shared types and helpers for the model operand bus feeder.
// Holds the deserializer state encoding and bus geometry functions.
package model_bus_pkg;

    typedef enum logic [1:0] {
        FILL0,
        FILL1,
        HOLD
    } deser_state_t;

    function automatic int bus_width(input int hi, input int lo);
        return hi - lo + 1;
    endfunction

    function automatic int idx_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/model_input_deserializer_if.sv
// Serial-in / frame-out handshake bundle for the model input deserializer.
// Slave is the deserializer; master is whoever drives the stream and sinks frames.
interface model_input_deserializer_if #(
    parameter int HI = 2,
    parameter int LO = -2
);
    logic         s_valid;
    logic         s_ready;
    logic         s_data;
    logic         s_first;
    logic         m_valid;
    logic         m_ready;
    logic [HI:LO] o_i0;
    logic [LO:HI] o_i1;

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_first,
        input  m_ready,
        output s_ready,
        output m_valid,
        output o_i0,
        output o_i1
    );

    modport master (
        output s_valid,
        output s_data,
        output s_first,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  o_i0,
        input  o_i1
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones once reached.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/model_input_deserializer.sv
// Collects a serial bit stream into the i0/i1 operand buses of the model cell,
// hands off complete frames on valid/ready and counts framing errors.
module model_input_deserializer
    import model_bus_pkg::*;
#(
    parameter int HI    = 2,
    parameter int LO    = -2,
    parameter int ERR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    model_input_deserializer_if.slave  bus,
    output logic [ERR_W-1:0]           err_cnt
);
    localparam int W     = bus_width(HI, LO);
    localparam int IDX_W = idx_width(W);
    localparam int LAST  = W - 1;

    deser_state_t     r_state;
    deser_state_t     w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [W-1:0]     r_bus0;
    logic [W-1:0]     r_bus1;
    logic [W-1:0]     w_mask;
    logic             w_acc;
    logic             w_err;
    logic             w_wr0;
    logic             w_wr1;
    int               w_k;

    // Both buses place bit k at offset W-1-k: i0 is [HI:LO], i1 is [LO:HI].
    always_comb begin
        w_acc       = bus.s_valid && (r_state != HOLD);
        w_err       = w_acc && bus.s_first
                      && !((r_state == FILL0) && (r_idx == '0));
        w_k         = w_err ? 0 : int'(r_idx);
        w_mask      = W'(1) << (LAST - w_k);
        w_wr0       = w_acc && (w_err || (r_state == FILL0));
        w_wr1       = w_acc && !w_err && (r_state == FILL1);
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_wr0) begin
            if (w_k == LAST) begin
                w_state_nxt = FILL1;
                w_idx_nxt   = '0;
            end else begin
                w_state_nxt = FILL0;
                w_idx_nxt   = IDX_W'(w_k + 1);
            end
        end else if (w_wr1) begin
            if (w_k == LAST) begin
                w_state_nxt = HOLD;
                w_idx_nxt   = '0;
            end else begin
                w_idx_nxt   = IDX_W'(w_k + 1);
            end
        end else if ((r_state == HOLD) && bus.m_ready) begin
            w_state_nxt = FILL0;
            w_idx_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL0;
            r_idx   <= '0;
            r_bus0  <= '0;
            r_bus1  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_wr0) begin
                r_bus0 <= (r_bus0 & ~w_mask) | (bus.s_data ? w_mask : '0);
            end
            if (w_wr1) begin
                r_bus1 <= (r_bus1 & ~w_mask) | (bus.s_data ? w_mask : '0);
            end
        end
    end

    assign bus.s_ready = (r_state != HOLD);
    assign bus.m_valid = (r_state == HOLD);
    assign bus.o_i0    = r_bus0;
    assign bus.o_i1    = r_bus1;

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .i_inc   (w_err),
        .i_clr   (rst),
        .o_count (err_cnt)
    );
endmodule

// File: tb/tb_model_input_deserializer.sv
// Directed bench for model_input_deserializer with HI=2, LO=-2, ERR_W=8.
// Frame vectors are written first-bit-first as 10-bit values.
module tb_model_input_deserializer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] err_cnt;
    int         n_pass = 0;
    int         n_tot  = 0;

    always #5 clk = ~clk;

    model_input_deserializer_if #(.HI(2), .LO(-2)) bus();

    model_input_deserializer #(
        .HI    (2),
        .LO    (-2),
        .ERR_W (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    typedef struct {
        logic [9:0] bits;
        logic       first;
        logic [4:0] e_i0;
        logic [4:0] e_i1;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic send_bit(input logic d, input logic f);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_first = f;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
    endtask

    task automatic send_frame(input logic [9:0] f, input logic first);
        for (int i = 0; i < 10; i++) send_bit(f[9-i], first && (i == 0));
    endtask

    task automatic wait_mvalid(input string nm);
        int c;
        c = 0;
        @(negedge clk);
        while (!bus.m_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk(nm, {31'd0, bus.m_valid}, 32'd1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_mvalid"}, {31'd0, bus.m_valid}, 32'd0);
        chk({nm, "_sready"}, {31'd0, bus.s_ready}, 32'd1);
        chk({nm, "_i0"}, {27'd0, bus.o_i0}, 32'd0);
        chk({nm, "_i1"}, {27'd0, bus.o_i1}, 32'd0);
        chk({nm, "_err"}, {24'd0, err_cnt}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] h0;
        logic [4:0] h1;
        tbl[0] = '{10'b10110_01101, 1'b1, 5'b10110, 5'b01101};
        tbl[1] = '{10'b11111_00000, 1'b1, 5'b11111, 5'b00000};
        tbl[2] = '{10'b00001_10000, 1'b0, 5'b00001, 5'b10000};
        tbl[3] = '{10'b01010_10101, 1'b1, 5'b01010, 5'b10101};

        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 1'b0;
        bus.s_first = 1'b0;
        bus.m_ready = 1'b1;

        // reset
        do_reset(2);
        chk_reset_state("reset");

        // basic frame with latency
        for (int i = 0; i < 9; i++) send_bit(tbl[0].bits[9-i], i == 0);
        @(negedge clk);
        chk("s2_early_mvalid", {31'd0, bus.m_valid}, 32'd0);
        send_bit(tbl[0].bits[0], 1'b0);
        @(negedge clk);
        chk("s2_mvalid", {31'd0, bus.m_valid}, 32'd1);
        chk("s2_sready", {31'd0, bus.s_ready}, 32'd0);
        chk("s2_i0", {27'd0, bus.o_i0}, 32'b10110);
        chk("s2_i1", {27'd0, bus.o_i1}, 32'b01101);
        @(negedge clk);
        chk("s2_handoff", {31'd0, bus.m_valid}, 32'd0);
        chk("s2_sready_back", {31'd0, bus.s_ready}, 32'd1);
        chk("s2_held_i0", {27'd0, bus.o_i0}, 32'b10110);

        // table of frames
        for (int v = 0; v < 4; v++) begin
            send_frame(tbl[v].bits, tbl[v].first);
            wait_mvalid($sformatf("tbl%0d_mvalid", v));
            chk($sformatf("tbl%0d_i0", v), {27'd0, bus.o_i0}, {27'd0, tbl[v].e_i0});
            chk($sformatf("tbl%0d_i1", v), {27'd0, bus.o_i1}, {27'd0, tbl[v].e_i1});
            @(negedge clk);
            chk($sformatf("tbl%0d_done", v), {31'd0, bus.m_valid}, 32'd0);
        end
        chk("tbl_err", {24'd0, err_cnt}, 32'd0);

        // backpressure
        bus.m_ready = 1'b0;
        send_frame(tbl[0].bits, 1'b1);
        @(negedge clk);
        chk("bp_mvalid", {31'd0, bus.m_valid}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = c[0];
            bus.s_first = (c == 2);
            @(negedge clk);
            chk($sformatf("bp%0d_mvalid", c), {31'd0, bus.m_valid}, 32'd1);
            chk($sformatf("bp%0d_sready", c), {31'd0, bus.s_ready}, 32'd0);
            chk($sformatf("bp%0d_i0", c), {27'd0, bus.o_i0}, 32'b10110);
            chk($sformatf("bp%0d_i1", c), {27'd0, bus.o_i1}, 32'b01101);
        end
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("bp_handoff", {31'd0, bus.m_valid}, 32'd0);
        chk("bp_err", {24'd0, err_cnt}, 32'd0);

        // resync on 4th bit
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_frame(10'b11001_10011, 1'b1);
        wait_mvalid("rs_mvalid");
        chk("rs_err", {24'd0, err_cnt}, 32'd1);
        chk("rs_i0", {27'd0, bus.o_i0}, 32'b11001);
        chk("rs_i1", {27'd0, bus.o_i1}, 32'b10011);
        @(negedge clk);

        // saturation
        do_reset(1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 254; i++) send_bit(1'b1, 1'b1);
        @(negedge clk);
        chk("sat_254", {24'd0, err_cnt}, 32'd254);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
        @(negedge clk);
        chk("sat_255", {24'd0, err_cnt}, 32'd255);

        // reset during FILL1
        do_reset(1);
        for (int i = 0; i < 7; i++) send_bit(tbl[3].bits[9-i], i == 0);
        do_reset(1);
        chk_reset_state("rst_fill1");
        send_frame(tbl[1].bits, 1'b1);
        wait_mvalid("rf1_mvalid");
        chk("rf1_i0", {27'd0, bus.o_i0}, 32'b11111);
        chk("rf1_i1", {27'd0, bus.o_i1}, 32'b00000);
        @(negedge clk);

        // reset during HOLD
        bus.m_ready = 1'b0;
        send_frame(tbl[3].bits, 1'b1);
        @(negedge clk);
        chk("rh_pre_mvalid", {31'd0, bus.m_valid}, 32'd1);
        do_reset(1);
        chk_reset_state("rst_hold");
        bus.m_ready = 1'b1;
        send_frame(tbl[0].bits, 1'b0);
        wait_mvalid("rh_mvalid");
        h0 = bus.o_i0;
        h1 = bus.o_i1;
        chk("rh_i0", {27'd0, h0}, 32'b10110);
        chk("rh_i1", {27'd0, h1}, 32'b01101);
        @(negedge clk);
        chk("rh_done", {31'd0, bus.m_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
